div_unsigned_seq: RTL and testbench
===================================

DIV_UNSIGNED_SEQ -- requirements
Module: div_unsigned_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits; legal values are 4 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: unsigned numerator, captured when start is accepted.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: unsigned denominator, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-009 The block SHALL have port quotient, output, WIDTH bits: result quotient.
REQ-010 The block SHALL have port remainder, output, WIDTH bits: result remainder.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: error flag for a zero divisor, valid with done.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1 and divisor!=0, the block SHALL capture the operands, clear the partial remainder, load the iteration counter with WIDTH and go to RUN.
REQ-014 In IDLE with start=1 and divisor=0, the block SHALL go directly to DONE with quotient all-ones, remainder=dividend and div_by_zero=1.
REQ-015 In each RUN cycle, the block SHALL shift {R,Q} left by one bit, with the MSB of Q entering R.
REQ-016 In the same RUN cycle, the block SHALL form the WIDTH+1-bit trial value R_shifted minus divisor, using two's-complement add of inverted divisor plus 1.
REQ-017 If the trial value is non-negative (MSB=0), the block SHALL set R=trial and Q[0]=1; otherwise it SHALL set R=R_shifted and Q[0]=0.
REQ-018 The block SHALL decrement the iteration counter each RUN cycle and go to RUN->DONE after the WIDTH-th iteration.
REQ-019 In DONE, the block SHALL assert done for exactly one cycle, then return to IDLE.
REQ-020 The quotient and remainder outputs SHALL be registered and update only on entry to DONE.
REQ-021 Results SHALL hold stable until the next accepted start reaches DONE.
REQ-022 Latency SHALL be as follows: with start sampled at edge k, done is high in the cycle after edge k+WIDTH+1 for a nonzero divisor, and after edge k+1 for a zero divisor.
REQ-023 The block SHALL ignore start while busy=1, with no effect on the in-flight operation.
REQ-024 Operand inputs SHALL be don't-care after capture; changing them mid-RUN SHALL NOT alter the result.
REQ-025 If dividend<divisor, the block SHALL produce quotient=0 and remainder=dividend through the normal RUN path at full latency, with no early exit.
REQ-026 The block SHALL clear div_by_zero on every accepted start with a nonzero divisor.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL force IDLE regardless of state, including mid-RUN, and abandon the operation without asserting done.
REQ-028 Reset SHALL clear busy, done, div_by_zero, quotient, remainder, the counter and internal R/Q.
REQ-029 Reset SHALL take priority over start in the same cycle.

Structure
REQ-030 Package div_pkg SHALL hold the state enum type (IDLE, RUN, DONE) and the default width constant; the counter width SHALL be derived from WIDTH by clog2 of WIDTH+1.
REQ-031 The block SHALL contain exactly one sub-module, sub_trial: a combinational WIDTH+1-bit subtractor producing the difference and a negative flag.

Verification
REQ-032 The bench SHALL check: WIDTH=16, 100/7 -> quotient=14, remainder=2, div_by_zero=0, done exactly 17 cycles after start.
REQ-033 The bench SHALL check: 0xFFFF/1 -> quotient=0xFFFF, remainder=0; then 0xFFFF/0xFFFF -> quotient=1, remainder=0.
REQ-034 The bench SHALL check: 5/0 -> done 1 cycle after start, quotient=0xFFFF, remainder=5, div_by_zero=1; a following 9/3 -> quotient=3, remainder=0, div_by_zero=0.
REQ-035 The bench SHALL check: 3/10 -> quotient=0, remainder=3 after the full 17 cycles; start pulsed again during RUN -> no restart, result unchanged.
REQ-036 The bench SHALL check: start 1000/3, assert rst at RUN cycle 8 -> busy=0 and no done pulse; outputs zero; new 1000/3 -> quotient=333, remainder=1.

Source files
------------

// File: rtl/div_unsigned_seq_pkg.sv
// Shared types and constants for the sequential unsigned divider.
package div_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

endpackage

// File: rtl/div_unsigned_seq_sub_trial.sv
// Combinational WIDTH+1-bit trial subtractor used by each restoring-division step.
module sub_trial #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0]   minuend,
   input  logic [WIDTH-1:0] subtrahend,
   output logic [WIDTH-1:0] diff,
   output logic             negative
);

   logic [WIDTH:0] fullDiff;

   // Subtraction as minuend + ~subtrahend + 1 over the widened operand
   assign fullDiff = minuend + ~{1'b0, subtrahend} + {{WIDTH{1'b0}}, 1'b1};
   assign diff     = fullDiff[WIDTH-1:0];
   assign negative = fullDiff[WIDTH];

endmodule

// File: rtl/div_unsigned_seq.sv
// Sequential restoring unsigned divider: one quotient bit per clock, WIDTH iterations.
module div_unsigned_seq
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   state_e           state;
   state_e           nextState;
   logic [WIDTH-1:0] remReg;
   logic [WIDTH-1:0] quoReg;
   logic [WIDTH-1:0] divisorReg;
   logic [CW-1:0]    count;
   logic [WIDTH:0]   remShifted;
   logic [WIDTH-1:0] trialDiff;
   logic             trialNegative;
   logic [WIDTH-1:0] remNext;
   logic [WIDTH-1:0] quoNext;
   logic             lastIter;
   logic             divisorZero;

   // Shifting {R,Q} left moves the quotient MSB into the bottom of the partial remainder
   assign remShifted  = {remReg, quoReg[WIDTH-1]};
   assign divisorZero = (divisor == '0);
   assign lastIter    = (count == CW'(1));

   sub_trial #(.WIDTH(WIDTH)) u_sub_trial (
      .minuend   (remShifted),
      .subtrahend(divisorReg),
      .diff      (trialDiff),
      .negative  (trialNegative)
   );

   assign remNext = trialNegative ? remShifted[WIDTH-1:0] : trialDiff;
   assign quoNext = {quoReg[WIDTH-2:0], ~trialNegative};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) begin
               nextState = divisorZero ? DONE : RUN;
            end
         end
         RUN: begin
            if (lastIter) begin
               nextState = DONE;
            end
         end
         DONE: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // The done pulse is registered off the DONE state, so it lands one cycle after results load
   always_ff @(posedge clk) begin
      if (rst) begin
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         remReg      <= '0;
         quoReg      <= '0;
         divisorReg  <= '0;
         count       <= '0;
      end else begin
         done <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  if (divisorZero) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     quoReg      <= dividend;
                     remReg      <= '0;
                     divisorReg  <= divisor;
                     count       <= CW'(WIDTH);
                     div_by_zero <= 1'b0;
                  end
               end
            end
            RUN: begin
               remReg <= remNext;
               quoReg <= quoNext;
               count  <= count - CW'(1);
               if (lastIter) begin
                  quotient  <= quoNext;
                  remainder <= remNext;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unsigned_seq.sv
// Self-checking bench for div_unsigned_seq: directed corner cases plus random operands vs. arithmetic model.
module tb_div_unsigned_seq;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   int checks = 0;
   int errors = 0;

   div_unsigned_seq #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Issues one division and counts edges after the start edge until done is seen (bounded)
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input bit disturb, output int latency);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      latency = 0;
      while (!done && latency < 100) begin
         @(posedge clk);
         #1 latency++;
         if (disturb && latency == 5) begin
            start    = 1'b1;
            dividend = WIDTH'($urandom);
            divisor  = WIDTH'($urandom);
         end else if (disturb && latency == 6) begin
            start = 1'b0;
         end
      end
   endtask

   task automatic runAndCheck(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input bit disturb, input string tag);
      int               lat;
      int               expLat;
      logic [WIDTH-1:0] expQ;
      logic [WIDTH-1:0] expR;
      expQ   = (b == 0) ? {WIDTH{1'b1}} : a / b;
      expR   = (b == 0) ? a : a % b;
      expLat = (b == 0) ? 1 : WIDTH + 1;
      applyStimulus(a, b, disturb, lat);
      checkOutput({tag, "_latency"}, lat, expLat);
      checkOutput({tag, "_quo"}, quotient, expQ);
      checkOutput({tag, "_rem"}, remainder, expR);
      checkOutput({tag, "_dbz"}, div_by_zero, (b == 0));
      checkOutput({tag, "_busy"}, busy, 1'b0);
      @(posedge clk);
      #1;
      checkOutput({tag, "_donepulse"}, done, 1'b0);
      checkOutput({tag, "_quohold"}, quotient, expQ);
   endtask

   initial begin
      int sawDone;
      int pick;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;

      rst      = 1'b1;
      start    = 1'b1;
      dividend = 16'd55;
      divisor  = 16'd5;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_done", done, 1'b0);
      checkOutput("reset_quo", quotient, 0);
      checkOutput("reset_rem", remainder, 0);
      checkOutput("reset_dbz", div_by_zero, 1'b0);
      start = 1'b0;
      rst   = 1'b0;

      runAndCheck(16'd100, 16'd7, 1'b0, "d100_7");
      checkOutput("d100_7_q14", quotient, 14);
      checkOutput("d100_7_r2", remainder, 2);

      runAndCheck(16'hFFFF, 16'd1, 1'b0, "dffff_1");
      runAndCheck(16'hFFFF, 16'hFFFF, 1'b0, "dffff_ffff");
      checkOutput("dffff_ffff_q1", quotient, 1);

      runAndCheck(16'd5, 16'd0, 1'b0, "d5_0");
      checkOutput("d5_0_qones", quotient, 16'hFFFF);
      runAndCheck(16'd9, 16'd3, 1'b0, "d9_3");
      checkOutput("d9_3_dbzclr", div_by_zero, 1'b0);

      runAndCheck(16'd3, 16'd10, 1'b1, "d3_10_restart");
      checkOutput("d3_10_q0", quotient, 0);

      // Abandon a division partway through RUN
      @(negedge clk);
      dividend = 16'd1000;
      divisor  = 16'd3;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("midrst_busy", busy, 1'b0);
      checkOutput("midrst_done", done, 1'b0);
      checkOutput("midrst_quo", quotient, 0);
      checkOutput("midrst_rem", remainder, 0);
      checkOutput("midrst_dbz", div_by_zero, 1'b0);
      sawDone = 0;
      repeat (25) begin
         @(posedge clk);
         #1 if (done) sawDone++;
      end
      checkOutput("midrst_nodone", sawDone, 0);
      runAndCheck(16'd1000, 16'd3, 1'b0, "d1000_3");
      checkOutput("d1000_3_q333", quotient, 333);
      checkOutput("d1000_3_r1", remainder, 1);

      for (int i = 0; i < 24; i++) begin
         pick = $urandom_range(0, 9);
         ra   = WIDTH'($urandom_range(0, 65535));
         if (pick == 0) rb = '0;
         else if (pick < 4) rb = WIDTH'($urandom_range(1, 15));
         else rb = WIDTH'($urandom_range(1, 65535));
         runAndCheck(ra, rb, (pick == 5), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
